fetcher_q: RTL and testbench
============================

Name: fetcher_q

Overview:
Parametrised instruction-fetch unit with a decoupled fetch queue between the icache/branch-predictor front end and the decoder.
- Holds the PC, issues icache reads and applies the branch prediction.
- Pushes fetched entries {inst, pc, mis_pc, pd_tk} into a FIFO of depth QUEUE_DEPTH.
- Presents the FIFO head to the decoder over a valid/ready handshake.
- Adds over the previous fetcher: buffering, decoder back-pressure, a halt on JALR until ROB redirect, and a full flush on rollback.

Parameters:
- QUEUE_DEPTH, 4, fetch queue entries; power of 2, minimum 2.
- ADDR_WIDTH, 32, PC/address width.
- INST_WIDTH, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 4, sequential PC increment.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; when low, all state freezes.
- if_en  in  1  fetch enable; low blocks new fetches, draining continues.
- if_rb  in  1  rollback request from ROB.
- rob_rb_pc  in  ADDR_WIDTH  rollback target PC.
- cache_rd_en  out  1  icache read request.
- cache_rd_addr  out  ADDR_WIDTH  icache read address (= pc).
- cache_hit  in  1  icache returned an instruction for cache_rd_addr this cycle.
- cache_hit_inst  in  INST_WIDTH  returned instruction.
- bp_pb_pc  out  ADDR_WIDTH  PC probed at the predictor (= pc).
- bp_pb_inst  out  INST_WIDTH  instruction probed at the predictor (= cache_hit_inst).
- bp_pd_tk  in  1  predicted taken.
- bp_pd_off  in  ADDR_WIDTH  predicted offset, already sign-extended.
- id_rdy  in  1  decoder accepts the head entry.
- id_ena  out  1  head entry valid.
- id_inst  out  INST_WIDTH  head instruction.
- id_cur_pc  out  ADDR_WIDTH  head PC.
- id_mis_pc  out  ADDR_WIDTH  head misprediction-recovery PC.
- id_pd_tk  out  1  head prediction bit.
- fq_cnt  out  $clog2(QUEUE_DEPTH)+1  queue occupancy.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC; head/tail pointers=0; count=0; state=FETCH.
  - All queue storage cleared to 0, so id_inst/id_cur_pc/id_mis_pc/id_pd_tk read 0 and id_ena=0.
- States:
  - FETCH: normal fetching.
  - HALT: entered after pushing a JALR (opcode bits[6:0]=7'b1100111); no fetching; exit only via if_rb.
- Pop:
  - pop = rdy & id_ena & id_rdy & !if_rb.
  - Outputs are the head slot read directly from registered storage; id_ena = (count != 0).
- Space and request:
  - space = (count < QUEUE_DEPTH) | pop.
  - cache_rd_en = if_en & rdy & state==FETCH & space & !if_rb.
- Push:
  - push = cache_rd_en & cache_hit.
  - Entry = {cache_hit_inst, pc, bp_pd_tk ? pc+PC_INC : pc+bp_pd_off, bp_pd_tk}.
  - Next pc = bp_pd_tk ? pc+bp_pd_off : pc+PC_INC.
  - Adds wrap modulo 2^ADDR_WIDTH.
  - JALR: entry pushed with pd_tk forced 0 and mis_pc=pc+PC_INC; pc unchanged; state becomes HALT.
- Simultaneous push and pop: count unchanged; both pointers advance. This is legal when full.
- Priority per cycle: rst > !rdy (hold everything, including if_rb) > if_rb > push/pop.
- Rollback (if_rb & rdy):
  - Next cycle: count=0, head=tail=0, pc=rob_rb_pc, state=FETCH, id_ena=0.
  - No push and no pop occur in the rollback cycle.
  - First fetch from rob_rb_pc happens one cycle after if_rb.
- Latency: cache_hit in cycle N produces id_ena=1 in cycle N+1 (queue was empty).
- Cache miss: no push; pc holds; cache_rd_en stays high.
- Pointer wrap: pointers are log2(QUEUE_DEPTH) bits and wrap naturally.
- No overflow or underflow is possible: push requires space, pop requires count>0.

Test Plan:
- Reset then if_en=1, id_rdy=1, hits with bp_pd_tk=0 → id_cur_pc 0,4,8 on consecutive cycles; id_mis_pc = pc+bp_pd_off.
- Hit at pc=0x10 with bp_pd_tk=1, bp_pd_off=0x20 → entry mis_pc=0x14, pd_tk=1; next cache_rd_addr=0x30.
- id_rdy=0, continuous hits, QUEUE_DEPTH=4:
  - fq_cnt reaches 4, then cache_rd_en=0.
  - Raise id_rdy → push and pop in the same cycle; fq_cnt stays 4; entries pop in FIFO order.
- Push JALR 0x000080E7 at pc=0x8 → state HALT, cache_rd_en=0, entry pd_tk=0, mis_pc=0xC; if_rb with rob_rb_pc=0x100 → fetch resumes at 0x100.
- Queue holding 3 entries, if_rb=1 with rob_rb_pc=0x40 → next cycle fq_cnt=0, id_ena=0, cache_rd_addr=0x40; no pop in the rollback cycle.
- Two cases:
  - rdy=0 for 3 cycles mid-stream, with if_rb pulsed → pc, fq_cnt and outputs unchanged.
  - Async rst asserted mid-cycle → fq_cnt=0 and pc=RESET_PC immediately.

Source files
------------

// File: rtl/fetcher_q.sv
// fetcher_q: instruction-fetch unit with a decoupled fetch queue.
// Holds the PC, drives icache/predictor probes, pushes fetched entries
// {inst, pc, mis_pc, pd_tk} into a FIFO and presents the head to the
// decoder over a valid/ready handshake. A JALR halts fetching until the
// ROB rolls back; a rollback flushes the whole queue.
module fetcher_q #(
  parameter int                    QUEUE_DEPTH = 4,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INST_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_INC      = ADDR_WIDTH'(4)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           if_en,
  input  logic                           if_rb,
  input  logic [ADDR_WIDTH-1:0]          rob_rb_pc,
  output logic                           cache_rd_en,
  output logic [ADDR_WIDTH-1:0]          cache_rd_addr,
  input  logic                           cache_hit,
  input  logic [INST_WIDTH-1:0]          cache_hit_inst,
  output logic [ADDR_WIDTH-1:0]          bp_pb_pc,
  output logic [INST_WIDTH-1:0]          bp_pb_inst,
  input  logic                           bp_pd_tk,
  input  logic [ADDR_WIDTH-1:0]          bp_pd_off,
  input  logic                           id_rdy,
  output logic                           id_ena,
  output logic [INST_WIDTH-1:0]          id_inst,
  output logic [ADDR_WIDTH-1:0]          id_cur_pc,
  output logic [ADDR_WIDTH-1:0]          id_mis_pc,
  output logic                           id_pd_tk,
  output logic [$clog2(QUEUE_DEPTH):0]   fq_cnt
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Queue storage, one slot per entry field.
  logic [INST_WIDTH-1:0] inst_q  [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] cpc_q   [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] mpc_q   [QUEUE_DEPTH];
  logic                  tk_q    [QUEUE_DEPTH];

  logic                  pop, push, space, is_jalr;
  logic [ADDR_WIDTH-1:0] pc_seq, pc_tgt;
  logic [ADDR_WIDTH-1:0] ent_mis;
  logic                  ent_tk;

  assign pc_seq  = pc_q + PC_INC;
  assign pc_tgt  = pc_q + bp_pd_off;
  assign is_jalr = (cache_hit_inst[6:0] == OPC_JALR);

  // Handshakes: a rollback cycle neither pops nor pushes, and a full queue
  // still accepts a push when the head leaves in the same cycle.
  assign id_ena      = (cnt_q != '0);
  assign pop         = rdy & id_ena & id_rdy & ~if_rb;
  assign space       = (cnt_q < CW'(QUEUE_DEPTH)) | pop;
  assign cache_rd_en = if_en & rdy & (state_q == FETCH) & space & ~if_rb;
  assign push        = cache_rd_en & cache_hit;

  // A JALR target is unknown here, so it is recorded as not-taken with the
  // fall-through as recovery PC; the ROB redirect supplies the real target.
  assign ent_tk  = bp_pd_tk & ~is_jalr;
  assign ent_mis = (bp_pd_tk | is_jalr) ? pc_seq : pc_tgt;

  assign cache_rd_addr = pc_q;
  assign bp_pb_pc      = pc_q;
  assign bp_pb_inst    = cache_hit_inst;

  assign id_inst   = inst_q[head_q];
  assign id_cur_pc = cpc_q[head_q];
  assign id_mis_pc = mpc_q[head_q];
  assign id_pd_tk  = tk_q[head_q];
  assign fq_cnt    = cnt_q;

  // Next-state: rdy gates everything, rollback overrides push/pop.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    if (rdy) begin
      if (if_rb) begin
        state_d = FETCH;
        pc_d    = rob_rb_pc;
        head_d  = '0;
        tail_d  = '0;
        cnt_d   = '0;
      end else begin
        if (push) begin
          tail_d = tail_q + PW'(1);
          if (is_jalr) state_d = HALT;
          else         pc_d    = bp_pd_tk ? pc_tgt : pc_seq;
        end
        if (pop) head_d = head_q + PW'(1);
        case ({push, pop})
          2'b10:   cnt_d = cnt_q + CW'(1);
          2'b01:   cnt_d = cnt_q - CW'(1);
          default: cnt_d = cnt_q;
        endcase
      end
    end
  end

  // Control registers: state, PC, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  // Queue storage: cleared on reset, written at the tail on push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        inst_q[i] <= '0;
        cpc_q[i]  <= '0;
        mpc_q[i]  <= '0;
        tk_q[i]   <= 1'b0;
      end
    end else if (push) begin
      inst_q[tail_q] <= cache_hit_inst;
      cpc_q[tail_q]  <= pc_q;
      mpc_q[tail_q]  <= ent_mis;
      tk_q[tail_q]   <= ent_tk;
    end
  end

endmodule

// File: tb/tb_fetcher_q.sv
// Randomized scoreboard bench for fetcher_q. The reference model is a plain
// queue of expected entries plus a PC and a halted flag; the stimulus side
// pushes expected entries, a negedge monitor compares and pops them.
module tb_fetcher_q;
  localparam int QD = 4;
  localparam int AW = 32;
  localparam int IW = 32;

  typedef struct {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
    logic [AW-1:0] mis;
    logic          tk;
  } ent_t;

  logic          clk, rst, rdy, if_en, if_rb;
  logic [AW-1:0] rob_rb_pc;
  logic          cache_rd_en;
  logic [AW-1:0] cache_rd_addr;
  logic          cache_hit;
  logic [IW-1:0] cache_hit_inst;
  logic [AW-1:0] bp_pb_pc;
  logic [IW-1:0] bp_pb_inst;
  logic          bp_pd_tk;
  logic [AW-1:0] bp_pd_off;
  logic          id_rdy, id_ena;
  logic [IW-1:0] id_inst;
  logic [AW-1:0] id_cur_pc, id_mis_pc;
  logic          id_pd_tk;
  logic [$clog2(QD):0] fq_cnt;

  fetcher_q #(.QUEUE_DEPTH(QD), .ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_en(if_en), .if_rb(if_rb),
    .rob_rb_pc(rob_rb_pc), .cache_rd_en(cache_rd_en),
    .cache_rd_addr(cache_rd_addr), .cache_hit(cache_hit),
    .cache_hit_inst(cache_hit_inst), .bp_pb_pc(bp_pb_pc),
    .bp_pb_inst(bp_pb_inst), .bp_pd_tk(bp_pd_tk), .bp_pd_off(bp_pd_off),
    .id_rdy(id_rdy), .id_ena(id_ena), .id_inst(id_inst),
    .id_cur_pc(id_cur_pc), .id_mis_pc(id_mis_pc), .id_pd_tk(id_pd_tk),
    .fq_cnt(fq_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   passed = 0;
  bit   run = 0;
  ent_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: decoder side of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        chk("fq_cnt", 64'(fq_cnt), 64'(sbq.size()));
        chk("id_ena", 64'(id_ena), 64'(sbq.size() != 0));
        if (sbq.size() != 0) begin
          chk("id_inst",   64'(id_inst),   64'(sbq[0].inst));
          chk("id_cur_pc", 64'(id_cur_pc), 64'(sbq[0].pc));
          chk("id_mis_pc", 64'(id_mis_pc), 64'(sbq[0].mis));
          chk("id_pd_tk",  64'(id_pd_tk),  64'(sbq[0].tk));
          if (rdy && id_rdy && !if_rb) void'(sbq.pop_front());
        end
      end
    end
  end

  // Stimulus + fetch-side model.
  logic [AW-1:0] m_pc;
  bit            halted;
  bit            p_rdy, p_rb, p_push, p_jalr;
  logic [AW-1:0] p_rbpc, p_npc;
  ent_t          p_e;

  initial begin
    bit en_m, pop_m, jalr;
    int phase;
    rst = 1'b1; rdy = 0; if_en = 0; if_rb = 0; rob_rb_pc = '0;
    cache_hit = 0; cache_hit_inst = '0; bp_pd_tk = 0; bp_pd_off = '0; id_rdy = 0;
    m_pc = '0; halted = 0; p_rdy = 0; p_rb = 0; p_push = 0; p_jalr = 0;
    p_rbpc = '0; p_npc = '0; p_e = '{default: '0};
    #12;
    chk("rst_fq_cnt",   64'(fq_cnt),        64'd0);
    chk("rst_id_ena",   64'(id_ena),        64'd0);
    chk("rst_id_inst",  64'(id_inst),       64'd0);
    chk("rst_cur_pc",   64'(id_cur_pc),     64'd0);
    chk("rst_mis_pc",   64'(id_mis_pc),     64'd0);
    chk("rst_pd_tk",    64'(id_pd_tk),      64'd0);
    chk("rst_rd_addr",  64'(cache_rd_addr), 64'd0);
    @(posedge clk); #1 rst = 1'b0; run = 1;

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      if (p_rdy) begin
        if (p_rb) begin
          sbq.delete(); m_pc = p_rbpc; halted = 0;
        end else if (p_push) begin
          sbq.push_back(p_e);
          if (p_jalr) halted = 1; else m_pc = p_npc;
        end
      end
      #1;
      phase = (c / 400) % 3;
      rdy   = ($urandom % 10) != 0;
      if_en = ($urandom % 8) != 0;
      if_rb = ($urandom % (halted ? 4 : 50)) == 0;
      rob_rb_pc = AW'({$urandom % 1024, 2'b00});
      cache_hit = ($urandom % 4) != 0;
      cache_hit_inst = $urandom;
      if (($urandom % 15) == 0) cache_hit_inst = 32'h000080E7;
      else if (cache_hit_inst[6:0] == 7'h67) cache_hit_inst[0] = 1'b0;
      bp_pd_tk  = ($urandom % 3) == 0;
      bp_pd_off = AW'(int'($urandom_range(0, 64)) * 4 - 128);
      id_rdy = (phase == 0) ? (($urandom % 8) == 0) :
               (phase == 1) ? (($urandom % 4) != 0) : (($urandom % 2) == 0);
      #1;
      pop_m = rdy && sbq.size() != 0 && id_rdy && !if_rb;
      en_m  = if_en && rdy && !halted && (sbq.size() < QD || pop_m) && !if_rb;
      chk("cache_rd_en",   64'(cache_rd_en),   64'(en_m));
      chk("cache_rd_addr", 64'(cache_rd_addr), 64'(m_pc));
      chk("bp_pb_inst",    64'(bp_pb_inst),    64'(cache_hit_inst));
      jalr   = cache_hit_inst[6:0] == 7'h67;
      p_rdy  = rdy;
      p_rb   = if_rb;
      p_rbpc = rob_rb_pc;
      p_push = en_m && cache_hit;
      p_jalr = jalr;
      p_e.inst = cache_hit_inst;
      p_e.pc   = m_pc;
      p_e.tk   = bp_pd_tk && !jalr;
      p_e.mis  = (jalr || bp_pd_tk) ? m_pc + 4 : m_pc + bp_pd_off;
      p_npc    = bp_pd_tk ? m_pc + bp_pd_off : m_pc + 4;
    end

    // Asynchronous reset in the middle of a cycle takes effect at once.
    run = 0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("arst_fq_cnt",  64'(fq_cnt),        64'd0);
    chk("arst_id_ena",  64'(id_ena),        64'd0);
    chk("arst_rd_addr", 64'(cache_rd_addr), 64'd0);
    chk("arst_cur_pc",  64'(id_cur_pc),     64'd0);
    #10 rst = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
